// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: holds {pc, instr} pairs in FIFO order with
// valid/ready on both sides and a single-cycle flush for branch/jump redirects.
module if_id_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter logic [XLEN-1:0] NOP = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_pc_plus4,
    output logic [XLEN-1:0]            out_instr,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic   push;
    logic   pop;
    logic   not_empty;
    entry_t head;

    // Handshakes depend only on registered occupancy, so a full queue never
    // accepts a word in the same cycle it drains one.
    assign not_empty = (count_q != CW'(0));
    assign push      = in_valid & (count_q != CW'(DEPTH));
    assign pop       = out_ready & not_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: in_pc, instr: in_instr};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; its contents are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        in_ready     = (count_q != CW'(DEPTH));
        out_valid    = not_empty;
        count        = count_q;
        out_pc       = '0;
        out_instr    = NOP;
        out_illegal  = 1'b0;
        if (not_empty) begin
            out_pc      = head.pc;
            out_instr   = head.instr;
            out_illegal = (head.instr[1:0] != 2'b11);
        end
        out_pc_plus4 = out_pc + XLEN'(4);
    end

endmodule
